spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Buffering front end placed directly upstream of `spi_master`. Accepts host words into a TX FIFO and feeds them one at a time into the core's single-entry `tx_buf` (`wr_en` / `tx_not_empty`). Drains each received word from the core's `rx_buf` (`rx_not_empty` / `read`) into an RX FIFO, which the host pops with a valid/ready handshake. This lets back-to-back SPI transfers run without host intervention per byte.

## Interface
- `WIDTH`, 8, word width; must match the `spi_master` instance.
- `DEPTH`, 8, entries per FIFO; power of two, ≥ 2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_tx_data` in WIDTH: word to transmit.
- `host_tx_valid` in 1: host offers `host_tx_data`.
- `host_tx_ready` out 1: TX FIFO not full.
- `host_rx_data` out WIDTH: head of RX FIFO (first-word fall-through).
- `host_rx_valid` out 1: RX FIFO not empty.
- `host_rx_ready` in 1: host pops the RX head.
- `tx_flush` in 1: synchronous clear of the TX FIFO.
- `tx_count` out $clog2(DEPTH)+1: TX occupancy.
- `rx_count` out $clog2(DEPTH)+1: RX occupancy.
- `rx_overflow` out 1: sticky flag, set when an RX word arrives while the RX FIFO is full.
- `clear_overflow` in 1: clears `rx_overflow`.
- `core_tx_data` out WIDTH: registered; connects to core `tx_data`.
- `core_wr_en` out 1: registered one-cycle pulse; connects to core `wr_en`.
- `core_tx_not_empty` in 1: from core `tx_not_empty`.
- `core_rx_data` in WIDTH: from core `rx_data`.
- `core_rx_not_empty` in 1: from core `rx_not_empty`.
- `core_read` out 1: registered one-cycle pulse; connects to core `read`.

## Operation
**Reset values**
- Both FIFOs empty; `tx_count` = `rx_count` = 0.
- `host_tx_ready` = 1, `host_rx_valid` = 0, `host_rx_data` = 0.
- `core_tx_data` = 0, `core_wr_en` = 0, `core_read` = 0, `rx_overflow` = 0.
- Both FSMs in IDLE.
- Asserting reset mid-transfer discards every buffered word. Pulses already issued to the core are not retracted.

**TX FIFO**
- A push occurs when `host_tx_valid` && `host_tx_ready`.
- Simultaneous push and feeder pop: count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- `tx_flush` empties the FIFO and overrides any same-cycle push and pop. It does not affect the feeder FSM or a pulse already in flight.

**TX feeder FSM**
- T_IDLE → T_PUSH when the TX FIFO is not empty && `core_tx_not_empty` == 0 && !`tx_flush`. On that edge: `core_tx_data` ← head, `core_wr_en` ← 1, pop.
- T_PUSH → T_HOLD unconditionally. `core_wr_en` ← 0.
- T_HOLD → T_IDLE unconditionally. This guard cycle covers the core's registered `tx_not_empty` rise.

**RX drain FSM**
- R_IDLE → R_HOLD when `core_rx_not_empty` == 1. On that edge: `core_read` ← 1, and `core_rx_data` is written to the RX FIFO.
- R_HOLD → R_IDLE unconditionally. `core_read` ← 0.

**RX FIFO**
- A pop occurs when `host_rx_valid` && `host_rx_ready`.
- Drain write and host pop in the same cycle are both performed.
- Write when full (with no same-cycle pop): `rx_overflow` ← 1; data handling is set by Configuration.
- If `clear_overflow` and a new overflow occur in the same cycle, set wins.

## Timing
- TX latency: host push accepted at edge E → `tx_count` = 1 after E → `core_wr_en` high from E+1 to E+2. Earliest next pulse is at E+4, and only if `core_tx_not_empty` is low.
- RX latency: `core_rx_not_empty` sampled high at edge R → `host_rx_valid` = 1 and `core_read` high from R to R+1.
- Minimum spacing: ≥ 3 cycles between `core_wr_en` pulses and ≥ 2 cycles between `core_read` pulses.
- Counts update on the edge after the handshake.
- Both `core_wr_en` and `core_read` are exactly one cycle wide.

## Configuration
- `SPI_MASTER_FIFO_RX_OVERWRITE_EN` defined: when the RX FIFO is full, the oldest entry is discarded and the new word is written. `rx_count` stays at DEPTH and the read pointer advances.
- Undefined: when the RX FIFO is full, the new word is dropped and the FIFO is unchanged.
- `rx_overflow` sets on a full write in both builds.

## Test plan
- **Reset defaults:** reset, then push 0xA5 → `core_wr_en` pulses once with `core_tx_data` = 0xA5 two edges after the push; `tx_count` returns to 0.
- **Hold while core busy:** fill the TX FIFO with 8 words (0x01..0x08) while `core_tx_not_empty` is held at 1 → `host_tx_ready` = 0 and no `core_wr_en`. Release `core_tx_not_empty` → words leave in order, each pulse ≥ 3 cycles apart.
- **Receive path:** pulse `core_rx_not_empty` with `core_rx_data` = 0x3C → single `core_read`; `host_rx_valid` = 1, `host_rx_data` = 0x3C; pop → `rx_count` = 0.
- **RX overflow:** deliver 9 words 0x10..0x18 without popping → `rx_overflow` = 1. Head is 0x11 with the macro defined, 0x10 without.
- **Simultaneous events:** `tx_flush` in the same cycle as a push → `tx_count` = 0. Also, `clear_overflow` in the same cycle as a new overflow → `rx_overflow` stays 1.
- **Reset mid-operation:** assert `rst_n` low with 4 words queued → all outputs return to reset values immediately, with no further `core_wr_en`.

Source files
------------

// File: rtl/spi_master_fifo.sv
// Buffering front end for spi_master: host TX FIFO feeding the core's tx_buf, core rx_buf drained into a host RX FIFO.
// Optional build macro SPI_MASTER_FIFO_RX_OVERWRITE_EN: on RX overflow discard the oldest word instead of the new one.
module spi_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       host_tx_data,
    input  logic                   host_tx_valid,
    output logic                   host_tx_ready,
    output logic [WIDTH-1:0]       host_rx_data,
    output logic                   host_rx_valid,
    input  logic                   host_rx_ready,
    input  logic                   tx_flush,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   rx_overflow,
    input  logic                   clear_overflow,
    output logic [WIDTH-1:0]       core_tx_data,
    output logic                   core_wr_en,
    input  logic                   core_tx_not_empty,
    input  logic [WIDTH-1:0]       core_rx_data,
    input  logic                   core_rx_not_empty,
    output logic                   core_read
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_PUSH = 2'd1;
    localparam logic [1:0] T_HOLD = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_HOLD = 1'b1;

    // ---------------- TX FIFO + feeder ----------------
    logic [WIDTH-1:0] r_tx_mem [DEPTH];
    logic [AW-1:0]    r_tx_wptr, r_tx_rptr;
    logic [CW-1:0]    r_tx_count;
    logic [1:0]       r_tx_state;
    logic [WIDTH-1:0] r_core_tx_data;
    logic             r_core_wr_en;
    logic             w_tx_push, w_tx_pop;

    assign host_tx_ready = (r_tx_count != FULL);
    assign w_tx_push     = host_tx_valid && host_tx_ready && !tx_flush;
    assign w_tx_pop      = (r_tx_state == T_IDLE) && (r_tx_count != '0) &&
                           !core_tx_not_empty && !tx_flush;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= host_tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else if (tx_flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + CW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - CW'(1);
        end
    end

    // T_HOLD is a guard cycle so the core's registered tx_not_empty is seen before the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state     <= T_IDLE;
            r_core_tx_data <= '0;
            r_core_wr_en   <= 1'b0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_state     <= T_PUSH;
                        r_core_tx_data <= r_tx_mem[r_tx_rptr];
                        r_core_wr_en   <= 1'b1;
                    end
                end
                T_PUSH: begin
                    r_tx_state   <= T_HOLD;
                    r_core_wr_en <= 1'b0;
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    assign tx_count     = r_tx_count;
    assign core_tx_data = r_core_tx_data;
    assign core_wr_en   = r_core_wr_en;

    // ---------------- RX drain + FIFO ----------------
    logic [WIDTH-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0]    r_rx_wptr, r_rx_rptr;
    logic [CW-1:0]    r_rx_count;
    logic [0:0]       r_rx_state;
    logic             r_core_read;
    logic             r_rx_overflow;
    logic             w_rx_wr, w_rx_pop, w_rx_full, w_rx_ovf, w_rx_store, w_rx_radv;

    assign w_rx_wr   = (r_rx_state == R_IDLE) && core_rx_not_empty;
    assign w_rx_pop  = host_rx_valid && host_rx_ready;
    assign w_rx_full = (r_rx_count == FULL);
    assign w_rx_ovf  = w_rx_wr && w_rx_full && !w_rx_pop;
`ifdef SPI_MASTER_FIFO_RX_OVERWRITE_EN
    assign w_rx_store = w_rx_wr;
`else
    assign w_rx_store = w_rx_wr && !w_rx_ovf;
`endif
    // An overwriting store into a full FIFO lands on the oldest slot, so the head moves on.
    assign w_rx_radv = w_rx_pop || (w_rx_store && w_rx_ovf);

    always_ff @(posedge clk) begin
        if (w_rx_store) r_rx_mem[r_rx_wptr] <= core_rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_store) r_rx_wptr <= r_rx_wptr + AW'(1);
            if (w_rx_radv)  r_rx_rptr <= r_rx_rptr + AW'(1);
            if (w_rx_store && !w_rx_pop && !w_rx_full) r_rx_count <= r_rx_count + CW'(1);
            else if (w_rx_pop && !w_rx_store)          r_rx_count <= r_rx_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state    <= R_IDLE;
            r_core_read   <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (r_rx_state == R_IDLE) begin
                if (w_rx_wr) begin
                    r_rx_state  <= R_HOLD;
                    r_core_read <= 1'b1;
                end
            end else begin
                r_rx_state  <= R_IDLE;
                r_core_read <= 1'b0;
            end
            if (w_rx_ovf)            r_rx_overflow <= 1'b1;
            else if (clear_overflow) r_rx_overflow <= 1'b0;
        end
    end

    assign host_rx_valid = (r_rx_count != '0);
    assign host_rx_data  = host_rx_valid ? r_rx_mem[r_rx_rptr] : '0;
    assign rx_count      = r_rx_count;
    assign rx_overflow   = r_rx_overflow;
    assign core_read     = r_core_read;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Scoreboard bench for spi_master_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_spi_master_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] host_tx_data = '0;
    logic             host_tx_valid = 1'b0;
    logic             host_tx_ready;
    logic [WIDTH-1:0] host_rx_data;
    logic             host_rx_valid;
    logic             host_rx_ready = 1'b0;
    logic             tx_flush = 1'b0;
    logic [CW-1:0]    tx_count, rx_count;
    logic             rx_overflow;
    logic             clear_overflow = 1'b0;
    logic [WIDTH-1:0] core_tx_data;
    logic             core_wr_en;
    logic             core_tx_not_empty = 1'b0;
    logic [WIDTH-1:0] core_rx_data = '0;
    logic             core_rx_not_empty = 1'b0;
    logic             core_read;

    always #5 clk = ~clk;

    spi_master_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .tx_flush(tx_flush), .tx_count(tx_count), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .clear_overflow(clear_overflow),
        .core_tx_data(core_tx_data), .core_wr_en(core_wr_en), .core_tx_not_empty(core_tx_not_empty),
        .core_rx_data(core_rx_data), .core_rx_not_empty(core_rx_not_empty), .core_read(core_read)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model + monitor ----------------
    logic [WIDTH-1:0] m_tx[$];
    logic [WIDTH-1:0] m_rx[$];
    logic             m_ovf = 1'b0;
    logic             m_hold = 1'b0;
    logic             snap_ok = 1'b0;
    logic             snap_busy, snap_flush, snap_push, snap_rne, snap_rrdy, snap_clr;
    logic [WIDTH-1:0] snap_txd, snap_rxd;
    int               cyc = 0;
    int               last_wr = -100;

    always @(negedge clk) begin : monitor
        logic [WIDTH-1:0] e;
        logic             pop, wr, newovf;
        cyc++;
        if (!rst_n) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf   = 1'b0;
            m_hold  = 1'b0;
            snap_ok = 1'b0;
            last_wr = -100;
            chk("rst_tx_count", 32'(tx_count), 0);
            chk("rst_rx_count", 32'(rx_count), 0);
            chk("rst_tx_ready", 32'(host_tx_ready), 1);
            chk("rst_rx_valid", 32'(host_rx_valid), 0);
            chk("rst_rx_data", 32'(host_rx_data), 0);
            chk("rst_core_tx_data", 32'(core_tx_data), 0);
            chk("rst_wr_en", 32'(core_wr_en), 0);
            chk("rst_read", 32'(core_read), 0);
            chk("rst_overflow", 32'(rx_overflow), 0);
        end else begin
            if (snap_ok) begin
                // TX: a pulse means the head left on the edge just passed
                if (core_wr_en) begin
                    chk("wr_en_while_blocked", 32'(snap_busy || snap_flush), 0);
                    chk("wr_en_spacing_ok", 32'(cyc - last_wr >= 3), 1);
                    last_wr = cyc;
                    if (m_tx.size() == 0) begin
                        chk("wr_en_with_empty_model", 32'(core_wr_en), 0);
                    end else begin
                        e = m_tx.pop_front();
                        chk("core_tx_data", 32'(core_tx_data), 32'(e));
                    end
                end
                if (snap_flush) m_tx.delete();
                else if (snap_push) m_tx.push_back(snap_txd);
                // RX
                pop    = snap_rrdy && (m_rx.size() > 0);
                wr     = snap_rne && !m_hold;
                newovf = wr && !pop && (m_rx.size() == DEPTH);
                if (pop) void'(m_rx.pop_front());
                if (wr) begin
                    if (m_rx.size() == DEPTH) begin
`ifdef SPI_MASTER_FIFO_RX_OVERWRITE_EN
                        void'(m_rx.pop_front());
                        m_rx.push_back(snap_rxd);
`endif
                    end else begin
                        m_rx.push_back(snap_rxd);
                    end
                end
                if (newovf) m_ovf = 1'b1;
                else if (snap_clr) m_ovf = 1'b0;
                m_hold = wr;
            end
            chk("tx_count", 32'(tx_count), 32'(m_tx.size()));
            chk("host_tx_ready", 32'(host_tx_ready), 32'(m_tx.size() < DEPTH));
            chk("rx_count", 32'(rx_count), 32'(m_rx.size()));
            chk("host_rx_valid", 32'(host_rx_valid), 32'(m_rx.size() > 0));
            if (m_rx.size() > 0) chk("host_rx_data", 32'(host_rx_data), 32'(m_rx[0]));
            chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
            chk("core_read", 32'(core_read), 32'(m_hold));
            snap_busy  = core_tx_not_empty;
            snap_flush = tx_flush;
            snap_push  = host_tx_valid && (m_tx.size() < DEPTH) && !tx_flush;
            snap_txd   = host_tx_data;
            snap_rne   = core_rx_not_empty;
            snap_rxd   = core_rx_data;
            snap_rrdy  = host_rx_ready;
            snap_clr   = clear_overflow;
            snap_ok    = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int pulses;
        logic [WIDTH-1:0] exp_head;
        repeat (3) step();
        rst_n = 1'b1;
        chk("init_tx_ready", 32'(host_tx_ready), 1);
        chk("init_rx_valid", 32'(host_rx_valid), 0);
        chk("init_wr_en", 32'(core_wr_en), 0);

        // single word latency
        host_tx_valid = 1'b1;
        host_tx_data  = 8'hA5;
        step();
        host_tx_valid = 1'b0;
        chk("lat_tx_count1", 32'(tx_count), 1);
        chk("lat_wr_en_low", 32'(core_wr_en), 0);
        step();
        chk("lat_wr_en_high", 32'(core_wr_en), 1);
        chk("lat_tx_data", 32'(core_tx_data), 'hA5);
        step();
        chk("lat_wr_en_width", 32'(core_wr_en), 0);
        step();
        chk("lat_tx_count0", 32'(tx_count), 0);

        // fill while core busy, then release
        core_tx_not_empty = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = WIDTH'(i);
            step();
        end
        host_tx_valid = 1'b0;
        chk("full_tx_ready", 32'(host_tx_ready), 0);
        chk("full_tx_count", 32'(tx_count), 8);
        step();
        chk("busy_no_wr_en", 32'(core_wr_en), 0);
        core_tx_not_empty = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (core_wr_en) pulses++;
        end
        chk("drain_pulses", 32'(pulses), 8);

        // receive path
        core_rx_data      = 8'h3C;
        core_rx_not_empty = 1'b1;
        step();
        core_rx_not_empty = 1'b0;
        chk("rx_read", 32'(core_read), 1);
        chk("rx_valid", 32'(host_rx_valid), 1);
        chk("rx_data", 32'(host_rx_data), 'h3C);
        step();
        chk("rx_read_width", 32'(core_read), 0);
        host_rx_ready = 1'b1;
        step();
        host_rx_ready = 1'b0;
        chk("rx_count_after_pop", 32'(rx_count), 0);

        // RX overflow
        for (int i = 0; i < 9; i++) begin
            core_rx_data      = WIDTH'(8'h10 + i);
            core_rx_not_empty = 1'b1;
            step();
            core_rx_not_empty = 1'b0;
            step();
        end
`ifdef SPI_MASTER_FIFO_RX_OVERWRITE_EN
        exp_head = 8'h11;
`else
        exp_head = 8'h10;
`endif
        chk("ovf_flag", 32'(rx_overflow), 1);
        chk("ovf_count", 32'(rx_count), 8);
        chk("ovf_head", 32'(host_rx_data), 32'(exp_head));
        clear_overflow    = 1'b1;
        core_rx_data      = 8'h19;
        core_rx_not_empty = 1'b1;
        step();
        clear_overflow    = 1'b0;
        core_rx_not_empty = 1'b0;
        chk("ovf_set_wins", 32'(rx_overflow), 1);
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(rx_overflow), 0);
        host_rx_ready = 1'b1;
        repeat (10) step();
        host_rx_ready = 1'b0;
        chk("ovf_drained", 32'(rx_count), 0);

        // flush beats a same-cycle push
        core_tx_not_empty = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = WIDTH'(8'h50 + i);
            step();
        end
        chk("pre_flush_count", 32'(tx_count), 2);
        host_tx_data = 8'h77;
        tx_flush     = 1'b1;
        step();
        tx_flush      = 1'b0;
        host_tx_valid = 1'b0;
        chk("flush_count", 32'(tx_count), 0);
        core_tx_not_empty = 1'b0;
        repeat (6) step();

        // reset with words queued
        core_tx_not_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = WIDTH'(8'hC0 + i);
            step();
        end
        host_tx_valid = 1'b0;
        chk("pre_rst_count", 32'(tx_count), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_count", 32'(tx_count), 0);
        chk("mid_rst_tx_ready", 32'(host_tx_ready), 1);
        chk("mid_rst_wr_en", 32'(core_wr_en), 0);
        step();
        step();
        rst_n = 1'b1;
        core_tx_not_empty = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (core_wr_en) pulses++;
        end
        chk("post_rst_pulses", 32'(pulses), 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            host_tx_valid     = ($urandom_range(0, 99) < 60);
            host_tx_data      = WIDTH'($urandom);
            core_tx_not_empty = ($urandom_range(0, 99) < 40);
            core_rx_not_empty = ($urandom_range(0, 99) < 35);
            core_rx_data      = WIDTH'($urandom);
            host_rx_ready     = ($urandom_range(0, 99) < 45);
            tx_flush          = ($urandom_range(0, 99) < 3);
            clear_overflow    = ($urandom_range(0, 99) < 5);
            step();
        end
        host_tx_valid     = 1'b0;
        core_tx_not_empty = 1'b0;
        core_rx_not_empty = 1'b0;
        tx_flush          = 1'b0;
        clear_overflow    = 1'b0;
        host_rx_ready     = 1'b1;
        repeat (60) step();
        chk("final_tx_count", 32'(tx_count), 0);
        chk("final_rx_count", 32'(rx_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
